// File: rtl/urg_scan_parser_if.sv
// Byte-level links of the URG scan parser: UART TX/RX handshakes and the sample stream.
interface urg_scan_parser_if;
    logic        start;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [15:0] data;
    logic [10:0] step;
    logic        enable;
    logic        scan_done;
    logic        error;
    logic        busy;

    modport master (
        input  start, tx_ready, rx_data, rx_valid,
        output tx_data, tx_valid, data, step, enable, scan_done, error, busy
    );

    modport slave (
        output start, tx_ready, rx_data, rx_valid,
        input  tx_data, tx_valid, data, step, enable, scan_done, error, busy
    );
endinterface

// File: rtl/urg_scan_parser.sv
// Sends the SCIP "GS" scan command to a URG rangefinder and turns the reply stream
// into 2-char range samples (data/step/enable) for the plotting stage.
module urg_scan_parser #(
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int MAX_POINTS     = 769,
    parameter int HEADER_LINES   = 3
) (
    input  logic              clk,
    input  logic              reset,
    urg_scan_parser_if.master bus
);

    typedef enum logic [1:0] {IDLE, SEND, HDR, DATA} state_t;

    localparam int         CMD_LEN = 13;
    localparam int         TW      = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int         LW      = $clog2(HEADER_LINES + 1);
    localparam logic [7:0] LF      = 8'h0A;
    localparam logic [7:0] ZERO    = 8'h30;

    state_t        state, state_next;
    logic [3:0]    cmd_idx;
    logic [LW-1:0] line_cnt;
    logic [1:0]    col;
    logic          error_pend;
    logic [7:0]    pend, half;
    logic          pend_v, half_v, line_open;
    logic [10:0]   index;
    logic [TW-1:0] wait_cnt;
    logic [15:0]   data_q;
    logic [10:0]   step_q;
    logic          enable_q, scan_done_q, error_q;

    logic rx_lf, waiting, timeout, status_bad, hdr_done, scan_end;

    function automatic logic [7:0] cmd_byte(input logic [3:0] idx);
        case (idx)
            4'd0:    cmd_byte = 8'h47;  // 'G'
            4'd1:    cmd_byte = 8'h53;  // 'S'
            4'd7:    cmd_byte = 8'h37;
            4'd8:    cmd_byte = 8'h36;
            4'd9:    cmd_byte = 8'h38;
            4'd11:   cmd_byte = 8'h31;
            4'd12:   cmd_byte = LF;
            default: cmd_byte = ZERO;
        endcase
    endfunction

    assign rx_lf      = bus.rx_valid && (bus.rx_data == LF);
    assign waiting    = (state == HDR) || (state == DATA);
    assign timeout    = waiting && !bus.rx_valid && (wait_cnt == TW'(TIMEOUT_CYCLES - 1));
    // A status line shorter than two chars reaches its LF early and counts as a mismatch.
    assign status_bad = (state == HDR) && bus.rx_valid && (line_cnt == LW'(1)) &&
                        (col < 2'd2) && (bus.rx_data != ZERO);
    assign hdr_done   = (state == HDR) && rx_lf && (line_cnt == LW'(HEADER_LINES - 1));
    assign scan_end   = (state == DATA) && rx_lf && !line_open;

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next   = state;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        unique case (state)
            IDLE: if (bus.start) state_next = SEND;
            SEND: begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = cmd_byte(cmd_idx);
                if (bus.tx_ready && (cmd_idx == 4'(CMD_LEN - 1))) state_next = HDR;
            end
            HDR: begin
                if (timeout || (hdr_done && (error_pend || status_bad))) state_next = IDLE;
                else if (hdr_done)                                       state_next = DATA;
            end
            DATA: if (timeout || scan_end) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; later writes in this block override the per-cycle strobe defaults.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cmd_idx     <= '0;
            line_cnt    <= '0;
            col         <= '0;
            error_pend  <= 1'b0;
            pend        <= '0;
            half        <= '0;
            pend_v      <= 1'b0;
            half_v      <= 1'b0;
            line_open   <= 1'b0;
            index       <= '0;
            wait_cnt    <= '0;
            data_q      <= '0;
            step_q      <= '0;
            enable_q    <= 1'b0;
            scan_done_q <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            enable_q    <= 1'b0;
            scan_done_q <= 1'b0;

            if (waiting && !bus.rx_valid && !timeout) wait_cnt <= wait_cnt + TW'(1);
            else                                      wait_cnt <= '0;
            if (timeout) error_q <= 1'b1;

            unique case (state)
                IDLE: if (bus.start) begin
                    error_q    <= 1'b0;
                    error_pend <= 1'b0;
                    cmd_idx    <= '0;
                    index      <= '0;
                end
                SEND: if (bus.tx_ready) begin
                    if (cmd_idx == 4'(CMD_LEN - 1)) begin
                        cmd_idx  <= '0;
                        line_cnt <= '0;
                        col      <= '0;
                    end else begin
                        cmd_idx <= cmd_idx + 4'd1;
                    end
                end
                HDR: if (bus.rx_valid) begin
                    if (status_bad) error_pend <= 1'b1;
                    if (rx_lf) begin
                        line_cnt <= line_cnt + LW'(1);
                        col      <= '0;
                        if (hdr_done) begin
                            if (error_pend || status_bad) error_q <= 1'b1;
                            pend_v    <= 1'b0;
                            half_v    <= 1'b0;
                            line_open <= 1'b0;
                        end
                    end else if (col != 2'd3) begin
                        col <= col + 2'd1;
                    end
                end
                DATA: if (bus.rx_valid) begin
                    if (!rx_lf) begin
                        pend      <= bus.rx_data;
                        pend_v    <= 1'b1;
                        line_open <= 1'b1;
                        // The lagged byte is known not to be a checksum: feed the pair assembler.
                        if (pend_v) begin
                            if (!half_v) begin
                                half   <= pend;
                                half_v <= 1'b1;
                            end else begin
                                half_v <= 1'b0;
                                if (index == 11'(MAX_POINTS)) begin
                                    error_q <= 1'b1;
                                end else begin
                                    data_q   <= {pend, half};
                                    step_q   <= index;
                                    enable_q <= 1'b1;
                                    index    <= index + 11'd1;
                                end
                            end
                        end
                    end else if (line_open) begin
                        pend_v    <= 1'b0;
                        line_open <= 1'b0;
                    end else begin
                        scan_done_q <= 1'b1;
                        if (half_v) error_q <= 1'b1;
                        half_v <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.data      = data_q;
    assign bus.step      = step_q;
    assign bus.enable    = enable_q;
    assign bus.scan_done = scan_done_q;
    assign bus.error     = error_q;
    assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_urg_scan_parser.sv
// Directed bench for urg_scan_parser: table of short scans plus hand-written corner sequences.
module tb_urg_scan_parser;
    localparam int TIMEOUT = 64;
    localparam int MAXP    = 769;

    typedef struct {
        string       status;
        string       body;
        int          n;
        logic [15:0] d_first;
        logic [15:0] d_last;
        int          step_last;
        bit          err;
        int          done;
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    urg_scan_parser_if bus();

    urg_scan_parser #(
        .TIMEOUT_CYCLES(TIMEOUT),
        .MAX_POINTS    (MAXP),
        .HEADER_LINES  (3)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int          pass_cnt  = 0;
    int          total_cnt = 0;
    int          done_cnt  = 0;
    logic [15:0] cap_data[$];
    int          cap_step[$];
    string       cmd_str   = "GS0000076801\n";
    vec_t        vecs[8];

    always @(negedge clk) begin
        if (bus.enable) begin
            cap_data.push_back(bus.data);
            cap_step.push_back(int'(bus.step));
        end
        if (bus.scan_done) done_cnt++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
        tick();
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic send_header(input string status);
        send_str(cmd_str);
        send_str({status, "\n"});
        send_str("1234X\n");
    endtask

    function automatic logic [7:0] char_at(input int pos);
        return 8'(8'h30 + (pos % 40));
    endfunction

    task automatic send_line(input int len);
        for (int j = 0; j < len; j++) send_byte(char_at(j));
        send_byte(8'h53);
        send_byte(8'h0A);
    endtask

    // Pulses start and accepts the command bytes, optionally stalling on byte 3.
    task automatic start_scan(input bit stall);
        logic [7:0] tx_log[$];
        int         stall_left;
        int         bad;
        bit         stall_now;
        stall_left = stall ? 5 : 0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int cyc = 0; cyc < 100 && tx_log.size() < 13; cyc++) begin
            stall_now    = (stall_left > 0) && (tx_log.size() == 3);
            bus.tx_ready = !stall_now;
            if (stall_now) stall_left--;
            @(negedge clk);
            if (stall_now) check("tx_hold", {bus.tx_valid, bus.tx_data}, {1'b1, 8'h30});
            if (bus.tx_valid && bus.tx_ready) tx_log.push_back(bus.tx_data);
            tick();
        end
        bus.tx_ready = 1'b1;
        bad = 0;
        for (int i = 0; i < 13; i++)
            if (i >= tx_log.size() || tx_log[i] != cmd_str[i]) bad++;
        check("tx_cmd_count", tx_log.size(), 13);
        check("tx_cmd_bytes", bad, 0);
        @(negedge clk);
        check("tx_idle_after_cmd", {bus.tx_valid, bus.busy}, 2'b01);
        tick();
    endtask

    task automatic run_vec(input vec_t v, input string tag, input bit stall);
        int b_n, b_done, n;
        b_n    = cap_data.size();
        b_done = done_cnt;
        start_scan(stall);
        send_header(v.status);
        send_str(v.body);
        repeat (4) tick();
        n = cap_data.size() - b_n;
        check({tag, "_enables"}, n, v.n);
        if (v.n > 0 && n == v.n) begin
            check({tag, "_first"}, {cap_data[b_n], 11'(cap_step[b_n])}, {v.d_first, 11'd0});
            check({tag, "_last"}, {cap_data[b_n+n-1], 11'(cap_step[b_n+n-1])},
                  {v.d_last, 11'(v.step_last)});
        end
        check({tag, "_error"}, bus.error, v.err);
        check({tag, "_done"}, done_cnt - b_done, v.done);
        check({tag, "_busy"}, bus.busy, 1'b0);
    endtask

    task automatic run_full(input bit extra, input string tag);
        int b_n, b_done, n, bad_step, bad_data, pos;
        b_n    = cap_data.size();
        b_done = done_cnt;
        start_scan(1'b0);
        send_header("00P");
        for (int l = 0; l < 24; l++) send_line(64);
        send_line(2);
        if (extra) send_str("0aZ\n");
        send_byte(8'h0A);
        repeat (4) tick();
        n        = cap_data.size() - b_n;
        bad_step = 0;
        bad_data = 0;
        for (int i = 0; i < n; i++) begin
            pos = (2 * i) % 64;
            if (cap_step[b_n+i] != i) bad_step++;
            if (cap_data[b_n+i] != {char_at(pos + 1), char_at(pos)}) bad_data++;
        end
        check({tag, "_enables"}, n, MAXP);
        check({tag, "_steps"}, bad_step, 0);
        check({tag, "_data"}, bad_data, 0);
        check({tag, "_done"}, done_cnt - b_done, 1);
        check({tag, "_error"}, bus.error, extra);
    endtask

    initial begin
        int  b_n, b_done, n;
        bit  timed;

        vecs[0] = '{"00P", "0a0bZ\n\n",      2, 16'h6130, 16'h6230, 1, 1'b0, 1};
        vecs[1] = '{"10Q", "0a0bZ\n\n",      0, 16'h0000, 16'h0000, 0, 1'b1, 0};
        vecs[2] = '{"01R", "0a0bZ\n\n",      0, 16'h0000, 16'h0000, 0, 1'b1, 0};
        vecs[3] = '{"0",   "0a0bZ\n\n",      0, 16'h0000, 16'h0000, 0, 1'b1, 0};
        vecs[4] = '{"00P", "0a0Z\n\n",       1, 16'h6130, 16'h6130, 0, 1'b1, 1};
        vecs[5] = '{"00P", "0a0Z\nbY\n\n",   2, 16'h6130, 16'h6230, 1, 1'b0, 1};
        vecs[6] = '{"00P", "\n",             0, 16'h0000, 16'h0000, 0, 1'b0, 1};
        vecs[7] = '{"00P", "0aZ\n0bY\n\n",   2, 16'h6130, 16'h6230, 1, 1'b0, 1};

        bus.start    = 1'b0;
        bus.tx_ready = 1'b1;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("reset_flags", {bus.busy, bus.tx_valid, bus.enable, bus.scan_done, bus.error}, 5'b0);
        check("reset_buses", {bus.tx_data, bus.step, bus.data}, 35'b0);
        tick();
        reset = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i), 1'b0);
        run_vec(vecs[0], "stall", 1'b1);

        // Stream stops mid-line: timeout aborts, then the next start clears error.
        b_n    = cap_data.size();
        b_done = done_cnt;
        start_scan(1'b0);
        send_header("00P");
        send_str("0a0");
        n     = 0;
        timed = 1'b0;
        for (int cyc = 0; cyc < 4 * TIMEOUT && !timed; cyc++) begin
            @(negedge clk);
            if (!bus.busy) timed = 1'b1;
            else n++;
            tick();
        end
        check("timeout_seen", timed, 1'b1);
        check("timeout_cycles", n, TIMEOUT - 1);
        check("timeout_error", bus.error, 1'b1);
        check("timeout_no_done", done_cnt - b_done, 0);
        check("timeout_enables", cap_data.size() - b_n, 1);
        b_n    = cap_data.size();
        b_done = done_cnt;
        start_scan(1'b0);
        check("error_cleared", bus.error, 1'b0);
        send_header("00P");
        send_str("0a0bZ\n\n");
        repeat (4) tick();
        check("retry_enables", cap_data.size() - b_n, 2);
        check("retry_done", done_cnt - b_done, 1);
        check("retry_error", bus.error, 1'b0);

        // Start pulsed mid-DATA is ignored; enable lands one cycle after the triggering byte.
        b_n    = cap_data.size();
        b_done = done_cnt;
        start_scan(1'b0);
        send_header("00P");
        send_str("0a");
        bus.rx_data  = 8'h30;
        bus.rx_valid = 1'b1;
        bus.start    = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
        bus.start    = 1'b0;
        @(negedge clk);
        check("latency_enable", {bus.enable, bus.data, bus.step}, {1'b1, 16'h6130, 11'd0});
        check("start_ignored", {bus.busy, bus.tx_valid}, 2'b10);
        tick();
        tick();
        send_str("bZ\n\n");
        repeat (4) tick();
        check("mid_start_enables", cap_data.size() - b_n, 2);
        check("mid_start_done", done_cnt - b_done, 1);
        check("mid_start_error", bus.error, 1'b0);

        // Reset mid-DATA clears every output on the next cycle.
        b_done = done_cnt;
        start_scan(1'b0);
        send_header("00P");
        send_str("0a0b");
        reset = 1'b0;
        tick();
        @(negedge clk);
        check("reset_mid_flags", {bus.busy, bus.enable, bus.scan_done, bus.error, bus.tx_valid}, 5'b0);
        check("reset_mid_buses", {bus.data, bus.step, bus.tx_data}, 35'b0);
        tick();
        reset = 1'b1;
        send_str("Z\n\n");
        repeat (2) tick();
        check("reset_mid_no_done", done_cnt - b_done, 0);

        run_full(1'b0, "full");
        run_full(1'b1, "overflow");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
